// File: rtl/filter_pkg.sv
// Shared definitions for the shift/weight streaming smoother.
// Mode encoding, width helpers and the output saturation function.
package filter_pkg;

    localparam logic MODE_WEIGHTED = 1'b0;
    localparam logic MODE_BOXCAR   = 1'b1;

    // Shift that divides by the tap count (tap count is a power of two).
    function automatic int tap_sh(input int taps);
        return $clog2(taps);
    endfunction

    // Width that holds the weighted sum without wrap.
    function automatic int sum_w_weighted(input int dw);
        return dw + 1;
    endfunction

    // Width that holds the boxcar sum without wrap.
    function automatic int sum_w_boxcar(input int dw, input int taps);
        return dw + $clog2(taps);
    endfunction

    // Clamp a sum to the largest dw-bit unsigned value.
    function automatic logic [31:0] saturate(input logic [31:0] sum, input int dw);
        logic [31:0] max_v;
        max_v = (32'd1 << dw) - 32'd1;
        return (sum > max_v) ? max_v : sum;
    endfunction

endpackage

// File: rtl/filter_tap_line.sv
// Sample history shift register with enable and synchronous clear.
// Tap 0 (newest) sits in the lowest DATA_W bits of o_taps.
module filter_tap_line #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic [DATA_W-1:0]        i_data,
    output logic [TAPS*DATA_W-1:0]   o_taps
);

    logic [TAPS*DATA_W-1:0] r_taps;

    // Shift the newest sample in at tap 0; clear wins over shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taps <= '0;
        end else if (i_clr) begin
            r_taps <= '0;
        end else if (i_en) begin
            r_taps <= {r_taps[(TAPS-1)*DATA_W-1:0], i_data};
        end
    end

    assign o_taps = r_taps;

endmodule

// File: rtl/shift_weight_filter.sv
// Streaming FIR smoother: weighted (x_k >> k) or boxcar mean, one-entry output stage.
// Optional rounding is enabled by defining FILTER_ROUND_EN.
module shift_weight_filter
    import filter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TAPS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_warm
);

    localparam int SH    = tap_sh(TAPS);
    localparam int ACC_W = sum_w_boxcar(DATA_W, TAPS) + 1;
    localparam int CNT_W = $clog2(TAPS + 1);

    logic [TAPS*DATA_W-1:0] w_taps;
    logic [DATA_W-1:0]      w_x [TAPS];
    logic [ACC_W-1:0]       w_wsum;
    logic [ACC_W-1:0]       w_bsum;
    logic [DATA_W-1:0]      w_res;
    logic                   w_accept;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_unused_tail;

    logic [CNT_W-1:0]       r_count;
    logic [DATA_W-1:0]      r_data;
    logic                   r_valid;
    logic                   r_warm;

    assign in_ready = !flush && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    filter_tap_line #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_taps (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (flush),
        .i_en   (w_accept),
        .i_data (in_data),
        .o_taps (w_taps)
    );

    // The oldest stored tap drops out of the window on the next accept.
    assign w_unused_tail = ^w_taps[TAPS*DATA_W-1 -: DATA_W];

    // Window for this accept: incoming sample plus the newest TAPS-1 taps.
    always_comb begin
        w_x[0] = in_data;
        for (int k = 1; k < TAPS; k++) begin
            w_x[k] = w_taps[(k-1)*DATA_W +: DATA_W];
        end
    end

    // Adder tree for both modes, then mode select and saturation.
    always_comb begin
        w_wsum = '0;
        w_bsum = '0;
        for (int k = 0; k < TAPS; k++) begin
            w_bsum = w_bsum + ACC_W'(w_x[k]);
`ifdef FILTER_ROUND_EN
            if (k == 0) begin
                w_wsum = w_wsum + ACC_W'(w_x[k]);
            end else begin
                w_wsum = w_wsum
                       + ((ACC_W'(w_x[k]) + (ACC_W'(1) << (k - 1))) >> k);
            end
`else
            w_wsum = w_wsum + (ACC_W'(w_x[k]) >> k);
`endif
        end
`ifdef FILTER_ROUND_EN
        w_bsum = w_bsum + ACC_W'(TAPS / 2);
`endif
        if (mode == MODE_BOXCAR) begin
            w_res = DATA_W'(w_bsum >> SH);
        end else begin
            w_res = DATA_W'(saturate(32'(w_wsum), DATA_W));
        end
    end

    assign w_cnt_next = (r_count == CNT_W'(TAPS)) ? r_count : r_count + CNT_W'(1);

    // Fill counter: one step per accepted sample, saturating at TAPS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= w_cnt_next;
        end
    end

    // Output register: load on accept, drop valid on a pop, hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_warm  <= 1'b0;
        end else if (flush) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_warm  <= 1'b0;
        end else if (w_accept) begin
            r_data  <= w_res;
            r_valid <= 1'b1;
            r_warm  <= (w_cnt_next == CNT_W'(TAPS));
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_warm  = r_warm;

endmodule
